// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the fifo read-side streaming master.
// Holds the read FSM state encoding and the credit rule used before each ren pulse.
package fifo_stream_reader_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int FIFO_DEPTH     = 1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_FLUSH
    } rd_state_e;

    // A read may only start if the fifo has data and every issued word still has a skid slot.
    function automatic logic creditOk(
        input logic        ffEmpty,
        input int unsigned inUse,
        input int unsigned limit,
        input logic        flush
    );
        return !ffEmpty && (inUse < limit) && !flush;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Register-based synchronous FIFO holding returned fifo words until the stream consumer takes them.
// The head entry is a register, so the downstream data/valid pair is registered.
module stream_skid_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_count != '0) && !i_clear;
    assign w_push = i_push && !i_clear && ((r_count != CNT_W'(DEPTH)) || w_pop);

    // Storage is cleared on reset so the stream data output starts at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the RAM-backed fifo: issues single-cycle ren pulses under a credit limit,
// absorbs variable return latency and presents returned words on a valid/ready stream.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int SKID_DEPTH     = 4,
    parameter int ISSUE_GAP      = 1,
    parameter int RVALID_TIMEOUT = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_ff_empty,
    output logic                            o_ff_ren,
    input  logic [DATA_W-1:0]               i_ff_rdata,
    input  logic                            i_ff_rvalid,
    input  logic                            i_flush,
    output logic [DATA_W-1:0]               o_m_data,
    output logic                            o_m_valid,
    input  logic                            i_m_ready,
    output logic [$clog2(SKID_DEPTH+1)-1:0] o_outstanding,
    output logic                            o_err_timeout
);

    localparam int OUT_W = $clog2(SKID_DEPTH + 1);
    localparam int TO_W  = $clog2(RVALID_TIMEOUT + 1);
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    rd_state_e        r_state;
    rd_state_e        w_nextState;
    logic [GAP_W-1:0] r_gapCnt;
    logic [OUT_W-1:0] r_outstanding;
    logic [TO_W-1:0]  r_toCnt;
    logic             r_errTimeout;

    logic             w_ren;
    logic             w_retValid;
    logic             w_push;
    logic             w_pop;
    logic             w_timeout;
    logic             w_creditOk;
    logic             w_skidValid;
    logic [OUT_W-1:0] w_skidCount;

    assign w_ren      = (r_state == S_REQ);
    assign w_retValid = i_ff_rvalid && (r_outstanding != '0);
    assign w_push     = w_retValid && !i_flush && (r_state != S_FLUSH);
    assign w_pop      = w_skidValid && i_m_ready && !i_flush;
    assign w_timeout  = (r_outstanding != '0) && !i_ff_rvalid
                        && (r_toCnt == TO_W'(RVALID_TIMEOUT - 1));

    // A ren issued this cycle is not yet in r_outstanding, so it is added here to avoid over-issuing.
    assign w_creditOk = creditOk(i_ff_empty,
                                 32'(r_outstanding) + 32'(w_skidCount) + 32'(w_ren),
                                 32'(SKID_DEPTH), i_flush);

    stream_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush),
        .i_push  (w_push),
        .i_data  (i_ff_rdata),
        .i_pop   (w_pop),
        .o_head  (o_m_data),
        .o_valid (w_skidValid),
        .o_count (w_skidCount)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_gapCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_gapCnt <= (r_state == S_GAP && w_nextState == S_GAP) ? r_gapCnt + 1'b1 : '0;
        end
    end

    // The last gap cycle re-checks credit itself so pulses can be exactly ISSUE_GAP idle cycles apart.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_creditOk) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                if (ISSUE_GAP > 0) begin
                    w_nextState = S_GAP;
                end else if (w_creditOk) begin
                    w_nextState = S_REQ;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gapCnt == GAP_W'(ISSUE_GAP - 1)) begin
                    w_nextState = w_creditOk ? S_REQ : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_outstanding == '0) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (w_timeout) begin
            w_nextState = S_IDLE;
        end
        if (i_flush) begin
            w_nextState = S_FLUSH;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outstanding <= '0;
            r_toCnt       <= '0;
            r_errTimeout  <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_outstanding <= '0;
            end else begin
                case ({w_ren, w_retValid})
                    2'b10:   r_outstanding <= r_outstanding + 1'b1;
                    2'b01:   r_outstanding <= r_outstanding - 1'b1;
                    default: r_outstanding <= r_outstanding;
                endcase
            end

            if (r_outstanding == '0 || i_ff_rvalid || w_timeout) begin
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + 1'b1;
            end

            if (i_flush) begin
                r_errTimeout <= 1'b0;
            end else if (w_timeout) begin
                r_errTimeout <= 1'b1;
            end
        end
    end

    assign o_ff_ren      = w_ren;
    assign o_m_valid     = w_skidValid;
    assign o_outstanding = r_outstanding;
    assign o_err_timeout = r_errTimeout;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a latency-programmable fifo model feeds the DUT and a
// scoreboard queue holds the words the stream must deliver, in order.
module tb_fifo_stream_reader;

    localparam int DATA_W         = 32;
    localparam int SKID_DEPTH     = 4;
    localparam int ISSUE_GAP      = 1;
    localparam int RVALID_TIMEOUT = 16;
    localparam int OUT_W          = $clog2(SKID_DEPTH + 1);

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              ffEmpty    = 1'b1;
    logic              ffRen;
    logic [DATA_W-1:0] ffRdata    = '0;
    logic              ffRvalid   = 1'b0;
    logic              flush      = 1'b0;
    logic [DATA_W-1:0] mData;
    logic              mValid;
    logic              mReady     = 1'b0;
    logic [OUT_W-1:0]  outstanding;
    logic              errTimeout;

    int assertCount = 0;
    int failCount   = 0;

    logic [DATA_W-1:0] fifoQ[$];
    logic [DATA_W-1:0] flightData[$];
    int                flightDue[$];
    logic [DATA_W-1:0] expQ[$];
    int                renCycles[$];
    int                cycleNum  = 0;
    int                renCount  = 0;
    int                retCount  = 0;
    int                readLat   = 1;
    int                delivered = 0;
    bit                dropNext  = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_W         (DATA_W),
        .SKID_DEPTH     (SKID_DEPTH),
        .ISSUE_GAP      (ISSUE_GAP),
        .RVALID_TIMEOUT (RVALID_TIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ff_empty    (ffEmpty),
        .o_ff_ren      (ffRen),
        .i_ff_rdata    (ffRdata),
        .i_ff_rvalid   (ffRvalid),
        .i_flush       (flush),
        .o_m_data      (mData),
        .o_m_valid     (mValid),
        .i_m_ready     (mReady),
        .o_outstanding (outstanding),
        .o_err_timeout (errTimeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Loads words into the fifo model; expected words also go to the scoreboard.
    task automatic applyStimulus(input logic [DATA_W-1:0] base, input int n, input bit expectIt);
        for (int i = 0; i < n; i++) begin
            fifoQ.push_back(base + DATA_W'(i));
            if (expectIt) begin
                expQ.push_back(base + DATA_W'(i));
            end
        end
    endtask

    task automatic waitDrain(input string tag, input int maxCycles);
        int k;
        k = 0;
        while ((expQ.size() != 0 || outstanding != '0) && k < maxCycles) begin
            tick(1);
            k++;
        end
        checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    endtask

    // Fifo model: pops on ren, returns the word readLat edges later (or never, if dropNext).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoQ.delete();
            flightData.delete();
            flightDue.delete();
            ffRvalid <= 1'b0;
            ffRdata  <= '0;
            ffEmpty  <= 1'b1;
        end else begin
            cycleNum++;
            ffRvalid <= 1'b0;
            if (flightDue.size() > 0 && flightDue[0] <= cycleNum) begin
                ffRvalid <= 1'b1;
                ffRdata  <= flightData.pop_front();
                void'(flightDue.pop_front());
                retCount++;
            end
            if (ffRen) begin
                renCount++;
                renCycles.push_back(cycleNum);
                if (fifoQ.size() > 0) begin
                    if (dropNext) begin
                        dropNext = 1'b0;
                        void'(fifoQ.pop_front());
                    end else begin
                        flightData.push_back(fifoQ.pop_front());
                        flightDue.push_back(cycleNum + readLat);
                    end
                end
            end
            ffEmpty <= (fifoQ.size() == 0);
        end
    end

    // Scoreboard: compare each accepted word and check the head is held while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mValid && mReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_valid", 32'(mValid), 32'd0);
                end else begin
                    checkOutput("stream_data", mData, expQ.pop_front());
                end
                delivered++;
            end else if (mValid && expQ.size() > 0) begin
                checkOutput("hold_data", mData, expQ[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;

        // Reset values, then an empty fifo must never see a read.
        tick(3);
        checkOutput("rst_ren", 32'(ffRen), 32'd0);
        checkOutput("rst_valid", 32'(mValid), 32'd0);
        checkOutput("rst_data", mData, 32'd0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_err", 32'(errTimeout), 32'd0);
        rst_n    = 1'b1;
        renCount = 0;
        tick(20);
        checkOutput("t1_no_ren", 32'(renCount), 32'd0);
        checkOutput("t1_valid", 32'(mValid), 32'd0);
        checkOutput("t1_outstanding", 32'(outstanding), 32'd0);

        // Streaming with consumer always ready.
        mReady    = 1'b1;
        readLat   = 1;
        renCount  = 0;
        delivered = 0;
        renCycles.delete();
        applyStimulus(32'd0, 10, 1'b1);
        waitDrain("t2", 300);
        checkOutput("t2_ren_count", 32'(renCount), 32'd10);
        checkOutput("t2_delivered", 32'(delivered), 32'd10);
        for (int i = 1; i < renCycles.size(); i++) begin
            checkOutput("t2_ren_spacing", 32'(renCycles[i] - renCycles[i-1]), 32'(ISSUE_GAP + 1));
        end

        // Stalled consumer: credit limits issue to SKID_DEPTH reads.
        mReady    = 1'b0;
        renCount  = 0;
        delivered = 0;
        applyStimulus(32'h300, 8, 1'b1);
        tick(40);
        checkOutput("t3_ren_stall", 32'(renCount), 32'(SKID_DEPTH));
        checkOutput("t3_valid", 32'(mValid), 32'd1);
        checkOutput("t3_head", mData, 32'h300);
        mReady = 1'b1;
        waitDrain("t3", 300);
        checkOutput("t3_ren_total", 32'(renCount), 32'd8);
        checkOutput("t3_delivered", 32'(delivered), 32'd8);

        // Flush with two words held and two reads in flight.
        mReady    = 1'b0;
        readLat   = 6;
        renCount  = 0;
        retCount  = 0;
        delivered = 0;
        applyStimulus(32'h400, 5, 1'b1);
        k = 0;
        while (!(renCount == 4 && retCount == 2 && !ffRvalid) && k < 100) begin
            tick(1);
            k++;
        end
        checkOutput("t4_setup_reached", 32'(k < 100), 32'd1);
        checkOutput("t4_inflight", 32'(outstanding), 32'd2);
        checkOutput("t4_valid_before", 32'(mValid), 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        checkOutput("t4_valid_cleared", 32'(mValid), 32'd0);
        checkOutput("t4_inflight_kept", 32'(outstanding), 32'd2);
        repeat (4) void'(expQ.pop_front());
        mReady = 1'b1;
        waitDrain("t4", 300);
        checkOutput("t4_ren_total", 32'(renCount), 32'd5);
        checkOutput("t4_delivered", 32'(delivered), 32'd1);

        // Withheld return: timeout, forced credit release, then normal issue.
        readLat   = 1;
        renCount  = 0;
        delivered = 0;
        dropNext  = 1'b1;
        applyStimulus(32'h500, 1, 1'b0);
        k = 0;
        while (renCount == 0 && k < 50) begin
            tick(1);
            k++;
        end
        checkOutput("t5_ren_seen", 32'(renCount), 32'd1);
        k = 0;
        while (!errTimeout && k < 40) begin
            tick(1);
            k++;
        end
        checkOutput("t5_timeout_cycles", 32'(k), 32'(RVALID_TIMEOUT));
        checkOutput("t5_outstanding_cleared", 32'(outstanding), 32'd0);
        applyStimulus(32'h510, 1, 1'b1);
        waitDrain("t5", 200);
        checkOutput("t5_delivered", 32'(delivered), 32'd1);
        checkOutput("t5_err_sticky", 32'(errTimeout), 32'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        checkOutput("t5_err_cleared", 32'(errTimeout), 32'd0);
        tick(2);

        // Asynchronous reset in the middle of a burst.
        renCount  = 0;
        delivered = 0;
        applyStimulus(32'h600, 10, 1'b1);
        k = 0;
        while (delivered < 5 && k < 200) begin
            tick(1);
            k++;
        end
        checkOutput("t6_burst_progress", 32'(delivered), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ren", 32'(ffRen), 32'd0);
        checkOutput("t6_rst_valid", 32'(mValid), 32'd0);
        checkOutput("t6_rst_data", mData, 32'd0);
        checkOutput("t6_rst_outstanding", 32'(outstanding), 32'd0);
        expQ.delete();
        tick(2);
        rst_n     = 1'b1;
        renCount  = 0;
        delivered = 0;
        tick(10);
        checkOutput("t6_no_ren_empty", 32'(renCount), 32'd0);
        applyStimulus(32'h700, 3, 1'b1);
        waitDrain("t6", 200);
        checkOutput("t6_delivered", 32'(delivered), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
